pipe_ctrl_chain: RTL and testbench



---
 rtl/pipe_ctrl_chain_pkg.sv | 25 ++
 rtl/pipe_ctrl_chain_if.sv | 22 ++
 rtl/pipe_ctrl_chain_stage.sv | 28 ++
 rtl/pipe_ctrl_chain.sv | 129 ++++++++++++
 tb/tb_pipe_ctrl_chain.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_chain_pkg.sv
// Shared definitions for the control-path pipeline: bundle field offsets,
// FSM state encoding and the bubble value.
package pipe_ctrl_pkg;

  localparam int CTRL_W_DEFAULT = 10;

  // Field offsets inside one control bundle: S is 2 bits, ALUControl is 3 bits
  localparam int REGWRITE_BIT = 0;
  localparam int MEMWRITE_BIT = 1;
  localparam int MEMTOREG_BIT = 2;
  localparam int ALUSRC_BIT   = 3;
  localparam int SBIT_LSB     = 4;
  localparam int ALUCTRL_LSB  = 6;
  localparam int PCSRC_BIT    = 9;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_state_t;

  // All-zero bundle: no register write and no memory write
  localparam logic [CTRL_W_DEFAULT-1:0] BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_chain_if.sv
// Decode-side handshake and per-stage control outputs of the control pipeline.
interface pipe_ctrl_chain_if #(
  parameter int CTRL_W = 10,
  parameter int STAGES = 3
);
  logic [CTRL_W-1:0]        ctrl_in;
  logic                     valid_in;
  logic                     stall_in;
  logic [STAGES-1:0]        flush_in;
  logic [STAGES*CTRL_W-1:0] ctrl_out;
  logic [STAGES-1:0]        valid_out;

  modport master (
    output ctrl_in, valid_in, stall_in, flush_in,
    input  ctrl_out, valid_out
  );

  modport slave (
    input  ctrl_in, valid_in, stall_in, flush_in,
    output ctrl_out, valid_out
  );
endinterface

// File: rtl/pipe_ctrl_chain_stage.sv
// One registered control stage: valid bit plus bundle, with flush and load select.
module pipe_ctrl_stage
  import pipe_ctrl_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              load,
  input  logic              valid_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  output logic              valid_q,
  output logic [CTRL_W-1:0] ctrl_q
);

  // Flush beats load; anything not loaded becomes a bubble
  always_ff @(posedge clk) begin
    if (reset || flush || !load) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_W'(BUBBLE);
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
    end
  end

endmodule

// File: rtl/pipe_ctrl_chain.sv
// Control-path pipeline ID/EX..MEM/WB with stall, flush, halt/drain FSM and counters.
// Define PIPE_PERF_CNT_EN to build the stall and bubble counters.
module pipe_ctrl_chain
  import pipe_ctrl_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEFAULT,
  parameter int STAGES = 3,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  pipe_ctrl_chain_if.slave bus,
  input  logic             halt_req,
  input  logic             resume_in,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             halted,
  output logic [CNT_W-1:0] retired_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] bubble_count
);

  pipe_state_t       state;
  logic              accept;
  logic              fetch_en;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] next_valid;
  logic [CTRL_W-1:0] ctrl_q [STAGES];

  assign accept       = bus.valid_in && (state == RUN) && !bus.stall_in;
  assign fetch_en     = (state == RUN) && !bus.stall_in;
  assign pc_enable    = fetch_en;
  assign if_id_enable = fetch_en;

  // Valids the stages will hold after this edge; DRAIN finishes when all are zero
  always_comb begin
    next_valid    = '0;
    next_valid[0] = accept && !bus.flush_in[0];
    for (int k = 1; k < STAGES; k++) begin
      next_valid[k] = valid_q[k-1] && !bus.flush_in[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic              load;
    logic              valid_d;
    logic [CTRL_W-1:0] ctrl_d;

    if (k == 0) begin : g_head
      assign load    = accept;
      assign valid_d = 1'b1;
      assign ctrl_d  = bus.ctrl_in;
    end else begin : g_tail
      assign load    = 1'b1;
      assign valid_d = valid_q[k-1];
      assign ctrl_d  = ctrl_q[k-1];
    end

    pipe_ctrl_stage #(.CTRL_W(CTRL_W)) u_stage (
      .clk     (clk),
      .reset   (reset),
      .flush   (bus.flush_in[k]),
      .load    (load),
      .valid_d (valid_d),
      .ctrl_d  (ctrl_d),
      .valid_q (valid_q[k]),
      .ctrl_q  (ctrl_q[k])
    );
  end

  always_comb begin
    bus.ctrl_out = '0;
    for (int k = 0; k < STAGES; k++) begin
      bus.ctrl_out[k*CTRL_W +: CTRL_W] = ctrl_q[k];
    end
  end
  assign bus.valid_out = valid_q;

  // halt_req wins over resume_in in RUN; halted trails the state by one edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      halted <= (state == HALTED);
      case (state)
        RUN:     if (halt_req) state <= DRAIN;
        DRAIN:   if (next_valid == '0) state <= HALTED;
        HALTED:  if (resume_in) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_count <= '0;
    end else if (valid_q[STAGES-1]) begin
      retired_count <= retired_count + CNT_W'(1);
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_q;

  // A stall and a stage-0 flush in the same cycle make a single bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else if (state == RUN) begin
      if (bus.stall_in) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (bus.stall_in || bus.flush_in[0]) begin
        bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_count  = stall_cnt_q;
  assign bubble_count = bubble_cnt_q;
`else
  assign stall_count  = '0;
  assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Scoreboard bench for pipe_ctrl_chain (CTRL_W=10, STAGES=3, CNT_W=4 to exercise counter wrap).
module tb_pipe_ctrl_chain;

  localparam int CTRL_W = 10;
  localparam int STAGES = 3;
  localparam int CNT_W  = 4;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             halt_req;
  logic             resume_in;
  logic             pc_enable;
  logic             if_id_enable;
  logic             halted;
  logic [CNT_W-1:0] retired_count;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] bubble_count;

  int checks = 0;
  int errors = 0;
  logic [CTRL_W-1:0] exp_q [$];

  pipe_ctrl_chain_if #(.CTRL_W(CTRL_W), .STAGES(STAGES)) bus ();

  pipe_ctrl_chain #(.CTRL_W(CTRL_W), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.slave),
    .halt_req      (halt_req),
    .resume_in     (resume_in),
    .pc_enable     (pc_enable),
    .if_id_enable  (if_id_enable),
    .halted        (halted),
    .retired_count (retired_count),
    .stall_count   (stall_count),
    .bubble_count  (bubble_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every cycle the last stage holds a valid bundle, it must match the scoreboard head
  always @(negedge clk) begin
    if (!reset && bus.valid_out[STAGES-1]) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL retire_unexpected: got %0h expected none", bus.ctrl_out[STAGES*CTRL_W-1 -: CTRL_W]);
      end else begin
        logic [CTRL_W-1:0] exp_ctrl;
        exp_ctrl = exp_q.pop_front();
        if (bus.ctrl_out[STAGES*CTRL_W-1 -: CTRL_W] !== exp_ctrl) begin
          errors++;
          $display("[TB] FAIL retire_ctrl: got %0h expected %0h", bus.ctrl_out[STAGES*CTRL_W-1 -: CTRL_W], exp_ctrl);
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [CTRL_W-1:0] ctrl, input logic valid, input logic stall,
                                input logic [STAGES-1:0] flush, input logic halt, input logic resume,
                                input bit will_retire);
    bus.ctrl_in  = ctrl;
    bus.valid_in = valid;
    bus.stall_in = stall;
    bus.flush_in = flush;
    halt_req     = halt;
    resume_in    = resume;
    if (will_retire) exp_q.push_back(ctrl);
    #1;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [CTRL_W-1:0] ctrl, input logic valid, input logic stall,
                      input logic [STAGES-1:0] flush, input logic halt, input logic resume,
                      input bit will_retire);
    apply_stimulus(ctrl, valid, stall, flush, halt, resume, will_retire);
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    apply_stimulus('0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle();
    cycle();
    check_output("reset_valid", 32'(bus.valid_out), 32'h0);
    check_output("reset_ctrl", 32'(bus.ctrl_out), 32'h0);
    check_output("reset_halted", 32'(halted), 32'h0);
    check_output("reset_retired", 32'(retired_count), 32'h0);
    check_output("reset_pc_en", 32'(pc_enable), 32'h1);
    reset = 1'b0;

    // Single bundle walks through all stages
    step(10'h2A5, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    check_output("t1_valid_e1", 32'(bus.valid_out), 32'h1);
    check_output("t1_s0_ctrl", 32'(bus.ctrl_out[9:0]), 32'h2A5);
    idle(2);
    check_output("t1_valid_e3", 32'(bus.valid_out), 32'h4);
    check_output("t1_s2_ctrl", 32'(bus.ctrl_out[29:20]), 32'h2A5);
    idle(1);
    check_output("t1_retired", 32'(retired_count), 32'h1);

    // Stream with a one-cycle load-use stall
    step(10'h101, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(10'h102, 1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    check_output("t2_pc_en_stall", 32'(pc_enable), 32'h0);
    check_output("t2_ifid_en_stall", 32'(if_id_enable), 32'h0);
    cycle();
    check_output("t2_valid_bubble", 32'(bus.valid_out), 32'h2);
    check_output("t2_s0_bubble", 32'(bus.ctrl_out[9:0]), 32'h0);
    check_output("t2_s1_ctrl", 32'(bus.ctrl_out[19:10]), 32'h101);
    check_output("t2_stall_cnt", 32'(stall_count), PERF ? 32'h1 : 32'h0);
    check_output("t2_bubble_cnt", 32'(bubble_count), PERF ? 32'h1 : 32'h0);
    step(10'h102, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(10'h103, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(10'h104, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(4);
    check_output("t2_retired", 32'(retired_count), 32'h5);

    // Flush stages 0 and 1 of a full pipe
    step(10'h201, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(10'h202, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(10'h203, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check_output("t3_full", 32'(bus.valid_out), 32'h7);
    apply_stimulus(10'h204, 1'b1, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0);
    check_output("t3_pc_en_flush", 32'(pc_enable), 32'h1);
    cycle();
    check_output("t3_valid_flush", 32'(bus.valid_out), 32'h4);
    check_output("t3_s01_ctrl", 32'(bus.ctrl_out[19:0]), 32'h0);
    check_output("t3_s2_ctrl", 32'(bus.ctrl_out[29:20]), 32'h202);
    check_output("t3_bubble_cnt", 32'(bubble_count), PERF ? 32'h2 : 32'h0);
    idle(3);
    check_output("t3_retired", 32'(retired_count), 32'h7);

    // Halt with a full pipe, drain, then resume
    step(10'h301, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(10'h302, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(10'h303, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    check_output("t4_drain_pc_en", 32'(pc_enable), 32'h0);
    check_output("t4_valid_e4", 32'(bus.valid_out), 32'h6);
    check_output("t4_halted_e4", 32'(halted), 32'h0);
    step(10'h3FF, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check_output("t4_valid_e5", 32'(bus.valid_out), 32'h4);
    idle(1);
    check_output("t4_valid_e6", 32'(bus.valid_out), 32'h0);
    idle(1);
    check_output("t4_halted", 32'(halted), 32'h1);
    check_output("t4_halted_pc_en", 32'(pc_enable), 32'h0);
    check_output("t4_retired", 32'(retired_count), 32'hA);
    step('0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    check_output("t4_resume_pc_en", 32'(pc_enable), 32'h1);
    idle(1);
    check_output("t4_unhalted", 32'(halted), 32'h0);

    // halt_req and resume_in together, then reset in DRAIN
    step(10'h401, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    check_output("t5_drain_pc_en", 32'(pc_enable), 32'h0);
    reset = 1'b1;
    idle(1);
    check_output("t5_valid", 32'(bus.valid_out), 32'h0);
    check_output("t5_ctrl", 32'(bus.ctrl_out), 32'h0);
    check_output("t5_retired", 32'(retired_count), 32'h0);
    check_output("t5_stall_cnt", 32'(stall_count), 32'h0);
    check_output("t5_bubble_cnt", 32'(bubble_count), 32'h0);
    check_output("t5_halted", 32'(halted), 32'h0);
    check_output("t5_pc_en", 32'(pc_enable), 32'h1);
    reset = 1'b0;

    // Seventeen retirements wrap a 4-bit counter to 1
    for (int i = 0; i < 17; i++) begin
      logic [CTRL_W-1:0] c;
      c = 10'h080 | CTRL_W'(i);
      step(c, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    end
    idle(4);
    check_output("t6_retired_wrap", 32'(retired_count), 32'h1);
    check_output("t6_stall_cnt", 32'(stall_count), 32'h0);
    check_output("t6_bubble_cnt", 32'(bubble_count), 32'h0);
    check_output("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
